seq_divider: RTL and testbench

//  Iterative restoring divider, one quotient bit per clock. It is the inverse

---
 rtl/seq_divider.sv | 91 +++++++++
 tb/tb_seq_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module seq_divider #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a, b, r, a_in, b_in, a_nx, r_nx, q_fix, r_fix;
  logic [WIDTH:0] r_sh, t;
  logic accept;
  assign accept = state == IDLE && start;
  assign busy = state == CALC;
  assign done = state == DONE;
  // a doubles as dividend shifter and quotient accumulator
  assign r_sh = {r, a[WIDTH-1]};
  assign t = r_sh + ~{1'b0, b} + 1'b1;
  assign r_nx = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
  assign a_nx = {a[WIDTH-2:0], ~t[WIDTH]};
`ifdef SEQ_DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa = is_signed & op_a[WIDTH-1];
  assign sb = is_signed & op_b[WIDTH-1];
  assign a_in = sa ? -op_a : op_a;
  assign b_in = sb ? -op_b : op_b;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  assign q_fix = neg_q ? -a_nx : a_nx;
  assign r_fix = neg_r ? -r_nx : r_nx;
`else
  logic unused_signed;
  assign unused_signed = is_signed;
  assign a_in = op_a;
  assign b_in = op_b;
  assign q_fix = a_nx;
  assign r_fix = r_nx;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      quot <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a <= a_in;
        b <= b_in;
        r <= '0;
        cnt <= '0;
        if (op_b == '0) begin
          quot <= '1;
          rem <= op_a;
          div_by_zero <= 1'b1;
          state <= DONE;
        end else state <= CALC;
      end
    end else if (state == CALC) begin
      a <= a_nx;
      r <= r_nx;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        quot <= q_fix;
        rem <= r_fix;
        div_by_zero <= 1'b0;
        state <= DONE;
      end
    end else state <= IDLE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table, handshake corner cases and random ops against a / and % model.
module tb_seq_divider;
`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, quot, rem;
  logic busy, done, div_by_zero;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] a, b;
    logic sg;
    logic [31:0] q, r;
    logic dz;
  } vec_t;
  vec_t vecs[9];

  seq_divider dut (.clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .op_a(op_a),
                   .op_b(op_b), .busy(busy), .done(done), .quot(quot), .rem(rem),
                   .div_by_zero(div_by_zero));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    dz = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sg && SEN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input int glitch_at, input string tag,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat, bc;
    @(negedge clk);
    op_a = a; op_b = b; is_signed = sg; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
    lat = 1; bc = 0;
    while (!done && lat < 80) begin
      if (busy) bc++;
      start = (lat == glitch_at);
      if (start) begin
        op_a = 32'd9; op_b = 32'd3;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, edz ? 1 : 33);
    chk({tag, " busy cycles"}, bc, edz ? 0 : 32);
    chk({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, edz});
    @(negedge clk);
    chk({tag, " done width"}, {31'b0, done}, 32'd0);
    chk({tag, " quot hold"}, quot, eq);
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic rs, edz;
    int k;
    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1};
    vecs[2] = '{32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[4] = '{32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0};
    vecs[5] = '{32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0};
`ifdef SEQ_DIV_SIGNED_EN
    vecs[6] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0};
    vecs[8] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0};
`else
    vecs[6] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0};
    vecs[8] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0};
`endif
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset quot", quot, 32'd0);
    chk("reset rem", rem, 32'd0);
    chk("reset dz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sg, -1, $sformatf("vec%0d", i),
             vecs[i].q, vecs[i].r, vecs[i].dz);
    // a second start mid-CALC must be dropped
    run_op(32'd100, 32'd7, 1'b0, 5, "busy_protect", 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst quot", quot, 32'd0);
    chk("midrst rem", rem, 32'd0);
    chk("midrst dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, -1, "after_rst", 32'hFFFFFFFF, 32'd0, 1'b0);
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd7; is_signed = 1'b0; start = 1'b1;
    k = 0;
    @(negedge clk);
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("b2b first done", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("b2b idle gap", {31'b0, busy | done}, 32'd0);
    @(negedge clk);
    chk("b2b reaccept", {31'b0, busy}, 32'd1);
    start = 1'b0;
    k = 0;
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("b2b second done", {31'b0, done}, 32'd1);
    chk("b2b second quot", quot, 32'd14);
    for (int i = 0; i < 1000; i++) begin
      k = $urandom_range(0, 7);
      ra = (k == 7) ? 32'h80000000 : $urandom;
      k = $urandom_range(0, 7);
      rb = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 15)) :
           (k == 2) ? 32'hFFFFFFFF : (k == 3) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      rs = 1'($urandom);
      model(ra, rb, rs, eq, er, edz);
      run_op(ra, rb, rs, -1, "rand", eq, er, edz);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
